panel_sequencer: RTL and testbench
==================================

# panel_sequencer

Executes the debounced front-panel commands (Clear, Extended Address Load, Address Load, Deposit, Examine, Continue) and sequences the panel's accesses to memory. It sits between the switch-debounce/trigger logic and the memory/CPU control. The block owns the panel-visible PC, IF and DF registers and the memory-buffer display register, and runs the memory request/acknowledge handshake with an optional timeout.

## Interface
- TMO_CYCLES, 64: cycles to wait for `mem_ack` before abort (only with PANEL_TIMEOUT_EN); must be ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- triggerd  in  1  debounced command strobe; held high ≥1 cycle per command
- cleard, extd_addrd, addr_loadd, depd, examd, contd  in  1 each  command qualifiers, valid while `triggerd`=1
- halted  in  1  CPU is halted
- sr  in  [0:11]  switch register
- mem_rdata  in  [0:11]  read data, valid with `mem_ack`
- mem_ack  in  1  completes the outstanding request
- mem_req  out  1  memory request
- mem_we  out  1  write when 1, read when 0; valid with `mem_req`
- mem_addr  out  [0:14]  {IF,PC} latched at command accept
- mem_wdata  out  [0:11]  SR latched at command accept
- pc  out  [0:11]  panel PC
- ifr, dfr  out  [0:2] each  instruction field and data field
- mb  out  [0:11]  last deposited or examined word
- clear_req  out  1  one-cycle pulse that clears AC, L and flags
- run_req  out  1  one-cycle pulse that resumes the CPU
- busy  out  1  state ≠ IDLE
- mem_err  out  1  sticky timeout flag

## Operation
- States: IDLE, CLR, EXTD, LOAD, DEP, EXAM, CONT.
- Accept rule: in IDLE, act on a rising edge of `triggerd` (registered previous value 0, current value 1). Edges that arrive while busy are discarded, not queued.
- Priority when several qualifiers are set: clear > extd_addr > addr_load > dep > exam > cont.
- `halted` gating: Clear, Extended Address Load, Address Load, Deposit and Examine are ignored unless `halted`=1. Continue is always accepted.
- If no qualifier is set, or the command is gated off: stay in IDLE, no outputs change.
- At accept: `mem_addr`←{ifr,pc}, `mem_wdata`←sr, `mem_err`←0, and go to the command state.
- CLR: `clear_req`=1 for one cycle, then IDLE.
- EXTD: ifr←sr[6:8], dfr←sr[9:11], then IDLE.
- LOAD: pc←sr, then IDLE.
- CONT: `run_req`=1 for one cycle, then IDLE.
- DEP: `mem_req`=1 and `mem_we`=1 until a cycle with `mem_ack`=1. On that edge: mb←mem_wdata, pc←pc+1, go to IDLE.
- EXAM: `mem_req`=1 and `mem_we`=0 until `mem_ack`=1. On that edge: mb←mem_rdata, pc←pc+1, go to IDLE.
- PC increments modulo 4096: 7777 wraps to 0000. IF and DF are never changed by the increment.
- `mem_ack` outside DEP/EXAM is ignored.
- Reset values: every register and output is 0, and state is IDLE.

## Timing
- Trigger rises at cycle T. The command state is entered at T+1.
- CLR, EXTD, LOAD, CONT each occupy exactly one cycle:
  - `clear_req`/`run_req` are high during T+1.
  - ifr/dfr/pc show the new value from T+2.
- DEP/EXAM: `mem_req` rises at T+1.
  - If `mem_ack` is present at T+1, mb and pc update at T+2 and `mem_req` is low at T+2.
  - Each extra wait cycle adds one cycle.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable for the whole request.
- `busy` is high exactly while a command state is active. The next trigger edge is accepted at the earliest in the cycle after `busy` falls.
- Reset mid-transaction takes effect at the next edge: `mem_req` is 0 in the cycle after reset is sampled, and no pc/mb update occurs.

## Configuration
- PANEL_TIMEOUT_EN defined:
  - A wait counter runs in DEP/EXAM. When `mem_ack` is absent for TMO_CYCLES consecutive request cycles, drop `mem_req`, set `mem_err`=1, leave pc and mb unchanged, and return to IDLE.
  - An ack arriving in the same cycle as expiry wins: the access completes normally.
- PANEL_TIMEOUT_EN undefined:
  - No counter; DEP/EXAM wait indefinitely.
  - `mem_err` is tied to 0 and TMO_CYCLES is unused.

## Test plan
- Load then deposit:
  - halted=1, sr=0200, Address Load → pc=0200.
  - sr=7402, Deposit with ack on the 3rd request cycle → write to addr 00200 data 7402; mb=7402; pc=0201.
- Examine with wrap: pc=7777, ifr=3, mem_rdata=1234, immediate ack → `mem_addr`=37777 during the request; mb=1234; pc=0000; ifr=3.
- Extended load: sr=0057, Extended Address Load → ifr=5, dfr=7; pc unchanged.
- Priority and gating:
  - dep and exam both set → only a write occurs.
  - halted=0 with Deposit → no `mem_req`.
  - halted=0 with Continue → one-cycle `run_req`.
- Busy and reset:
  - Second trigger edge during a pending DEP → ignored (exactly one write).
  - Reset asserted mid-request → `mem_req`=0 next cycle and all outputs 0.
- Timeout (PANEL_TIMEOUT_EN, TMO_CYCLES=8):
  - No ack → `mem_req` high for 8 cycles, then `mem_err`=1, pc unchanged.
  - Next accepted command → `mem_err` clears.

Source files
------------

// File: rtl/panel_sequencer.sv
// Front-panel command sequencer: decodes Clear/ExtLoad/Load/Dep/Exam/Cont, owns PC/IF/DF/MB, runs the memory req/ack handshake.
// Accept to command state in 1 cycle; memory commands hold mem_req until mem_ack. Optional timeout enabled by PANEL_TIMEOUT_EN.
module panel_sequencer #(
  parameter int TMO_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        triggerd,
  input  logic        cleard,
  input  logic        extd_addrd,
  input  logic        addr_loadd,
  input  logic        depd,
  input  logic        examd,
  input  logic        contd,
  input  logic        halted,
  input  logic [0:11] sr,
  input  logic [0:11] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic [0:11] pc,
  output logic [0:2]  ifr,
  output logic [0:2]  dfr,
  output logic [0:11] mb,
  output logic        clear_req,
  output logic        run_req,
  output logic        busy,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_EXTD, S_LOAD, S_DEP, S_EXAM, S_CONT
  } state_t;

  state_t state;
  state_t next_cmd;
  logic   trig_q;
  logic   accept;

  if (TMO_CYCLES < 2) begin : g_tmo_chk
    $error("panel_sequencer: TMO_CYCLES must be at least 2");
  end

  assign accept = triggerd && !trig_q && (state == S_IDLE);
  assign busy   = (state != S_IDLE);

  // Priority pick first, then halt gating: a gated winner suppresses the whole command.
  always_comb begin
    next_cmd = S_IDLE;
    if (cleard)          next_cmd = halted ? S_CLR  : S_IDLE;
    else if (extd_addrd) next_cmd = halted ? S_EXTD : S_IDLE;
    else if (addr_loadd) next_cmd = halted ? S_LOAD : S_IDLE;
    else if (depd)       next_cmd = halted ? S_DEP  : S_IDLE;
    else if (examd)      next_cmd = halted ? S_EXAM : S_IDLE;
    else if (contd)      next_cmd = S_CONT;
  end

`ifdef PANEL_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] wait_cnt;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      trig_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc        <= '0;
      ifr       <= '0;
      dfr       <= '0;
      mb        <= '0;
      clear_req <= 1'b0;
      run_req   <= 1'b0;
`ifdef PANEL_TIMEOUT_EN
      mem_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      trig_q    <= triggerd;
      clear_req <= 1'b0;
      run_req   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && next_cmd != S_IDLE) begin
            state     <= next_cmd;
            mem_addr  <= {ifr, pc};
            mem_wdata <= sr;
            clear_req <= (next_cmd == S_CLR);
            run_req   <= (next_cmd == S_CONT);
            mem_req   <= (next_cmd == S_DEP) || (next_cmd == S_EXAM);
            mem_we    <= (next_cmd == S_DEP);
`ifdef PANEL_TIMEOUT_EN
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
          end
        end
        S_CLR, S_CONT: state <= S_IDLE;
        S_EXTD: begin
          ifr   <= sr[6:8];
          dfr   <= sr[9:11];
          state <= S_IDLE;
        end
        S_LOAD: begin
          pc    <= sr;
          state <= S_IDLE;
        end
        S_DEP, S_EXAM: begin
          // An ack on the expiry cycle still completes the access.
          if (mem_ack) begin
            mb      <= (state == S_DEP) ? mem_wdata : mem_rdata;
            pc      <= pc + 12'd1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_IDLE;
          end
`ifdef PANEL_TIMEOUT_EN
          else if (wait_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_sequencer.sv
// Directed bench for panel_sequencer; timeout cases run only when PANEL_TIMEOUT_EN is defined.
module tb_panel_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        triggerd, cleard, extd_addrd, addr_loadd, depd, examd, contd, halted;
  logic [0:11] sr, mem_rdata, mem_wdata, pc, mb;
  logic        mem_ack, mem_req, mem_we, clear_req, run_req, busy, mem_err;
  logic [0:14] mem_addr;
  logic [0:2]  ifr, dfr;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  logic [0:14] wr_addr;
  logic [0:11] wr_data;

  localparam logic [5:0] Q_CLR  = 6'b100000;
  localparam logic [5:0] Q_EXT  = 6'b010000;
  localparam logic [5:0] Q_LOAD = 6'b001000;
  localparam logic [5:0] Q_DEP  = 6'b000100;
  localparam logic [5:0] Q_EXAM = 6'b000010;
  localparam logic [5:0] Q_CONT = 6'b000001;

  panel_sequencer #(.TMO_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .triggerd(triggerd), .cleard(cleard),
    .extd_addrd(extd_addrd), .addr_loadd(addr_loadd), .depd(depd), .examd(examd),
    .contd(contd), .halted(halted), .sr(sr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc(pc), .ifr(ifr), .dfr(dfr), .mb(mb), .clear_req(clear_req), .run_req(run_req),
    .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Records completed writes as seen on the memory port.
  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack && mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accept edge (first command-state cycle).
  task automatic issue(input logic [5:0] q);
    triggerd = 1'b1;
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = q;
    tick();
    triggerd = 1'b0;
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; triggerd = 0; {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'b0;
    halted = 1'b1; sr = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_pc", pc, 0);
    check("rst_ifdf", {ifr, dfr}, 0);
    check("rst_mb", mb, 0);
    check("rst_ctl", {mem_req, mem_we, clear_req, run_req, busy, mem_err}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);

    // Address load
    sr = 12'o0200;
    issue(Q_LOAD);
    check("load_busy", {busy, mem_req}, 2'b10);
    tick();
    check("load_pc", pc, 12'o0200);
    check("load_idle", busy, 0);

    // Deposit, ack on 3rd request cycle
    sr = 12'o7402;
    issue(Q_DEP);
    check("dep_req", {mem_req, mem_we}, 2'b11);
    check("dep_addr", mem_addr, 15'o00200);
    check("dep_wdata", mem_wdata, 12'o7402);
    tick();
    check("dep_wait", mem_req, 1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("dep_done_req", mem_req, 0);
    check("dep_mb", mb, 12'o7402);
    check("dep_pc", pc, 12'o0201);
    check("dep_wr", {wr_cnt[3:0], wr_addr, wr_data}, {4'd1, 15'o00200, 12'o7402});

    // Examine with PC wrap
    sr = 12'o0030;
    issue(Q_EXT); tick();
    sr = 12'o7777;
    issue(Q_LOAD); tick();
    mem_rdata = 12'o1234;
    issue(Q_EXAM);
    mem_ack = 1'b1;
    check("exam_addr", mem_addr, 15'o37777);
    check("exam_req", {mem_req, mem_we}, 2'b10);
    tick();
    mem_ack = 1'b0;
    check("exam_mb", mb, 12'o1234);
    check("exam_pc_wrap", pc, 12'o0000);
    check("exam_ifr", ifr, 3);
    check("exam_req_low", mem_req, 0);

    // Extended address load
    sr = 12'o0057;
    issue(Q_EXT);
    tick();
    check("ext_ifdf", {ifr, dfr}, {3'd5, 3'd7});
    check("ext_pc", pc, 12'o0000);

    // Priority: dep beats exam
    sr = 12'o1111; mem_rdata = 12'o2222;
    issue(Q_DEP | Q_EXAM);
    mem_ack = 1'b1;
    check("prio_we", {mem_req, mem_we}, 2'b11);
    tick();
    mem_ack = 1'b0;
    check("prio_mb", mb, 12'o1111);
    check("prio_wr", {wr_cnt[3:0], wr_addr}, {4'd2, 15'o50000});
    check("prio_pc", pc, 12'o0001);

    // Priority: clear beats continue
    issue(Q_CLR | Q_CONT);
    check("clr_pulse", {clear_req, run_req}, 2'b10);
    tick();
    check("clr_end", {clear_req, busy}, 2'b00);

    // Gating when running
    halted = 1'b0;
    issue(Q_DEP);
    check("gate_dep", {mem_req, busy}, 2'b00);
    tick();
    check("gate_dep2", {mem_req, pc}, {1'b0, 12'o0001});
    issue(Q_CONT);
    check("cont_run", {run_req, busy}, 2'b11);
    tick();
    check("cont_end", {run_req, busy}, 2'b00);
    halted = 1'b1;

    // Second trigger while a deposit is pending is dropped
    sr = 12'o2345;
    issue(Q_DEP);
    tick();
    triggerd = 1'b1; depd = 1'b1;
    tick();
    triggerd = 1'b0; depd = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick(); tick();
    check("busy_drop", {mem_req, busy}, 2'b00);
    check("busy_wr", wr_cnt, 3);
    check("busy_pc", pc, 12'o0002);

`ifdef PANEL_TIMEOUT_EN
    begin
      int cyc;
      issue(Q_DEP);
      cyc = 0;
      while (mem_req && cyc < 20) begin
        cyc++;
        tick();
      end
      check("tmo_cycles", cyc, 8);
      check("tmo_err", mem_err, 1);
      check("tmo_pc", {pc, mb}, {12'o0002, 12'o2345});
      sr = 12'o0100;
      issue(Q_LOAD);
      check("tmo_err_clr", mem_err, 0);
      tick();
      mem_rdata = 12'o4321;
      issue(Q_EXAM);
      repeat (7) tick();
      check("tmo_last_req", mem_req, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("tmo_ack_wins", {mem_err, mb, pc}, {1'b0, 12'o4321, 12'o0101});
    end
`endif

    // Reset in the middle of a request
    sr = 12'o5555;
    issue(Q_DEP);
    tick();
    reset = 1'b1; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_regs", {pc, mb, ifr, dfr}, 0);
    check("rst_mid_ctl", {busy, mem_we, mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
